// File: rtl/prog_priority_scheduler.sv
// prog_priority_scheduler
// Programmable-priority arbiter for 16 peripherals. A priority file is written
// and read through a valid/ready config port while idle. A sequential scan
// picks the highest-priority latched requester (ties go to the lower index),
// and the grant is held until the winner pulses gnt_done.
module prog_priority_scheduler #(
    parameter int NUM_REQ   = 16,
    parameter int PRI_WIDTH = 5,
    parameter int IDX_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic                 gnt_done,
    output logic                 gnt_valid,
    output logic [IDX_WIDTH-1:0] gnt_index,
    output logic [NUM_REQ-1:0]   gnt_onehot,
    output logic                 busy,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic                 cfg_wr_rd,
    input  logic [IDX_WIDTH-1:0] cfg_index,
    input  logic [PRI_WIDTH-1:0] cfg_wdata,
    output logic [PRI_WIDTH-1:0] cfg_rdata,
    output logic                 cfg_rvalid
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        GRANT
    } state_t;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_REQ - 1);

    state_t               state;
    logic [PRI_WIDTH-1:0] pri [NUM_REQ];
    logic [NUM_REQ-1:0]   req_q;
    logic [IDX_WIDTH-1:0] cnt;
    logic [IDX_WIDTH-1:0] best_idx;
    logic [PRI_WIDTH-1:0] best_pri;
    logic                 best_valid;

    logic [PRI_WIDTH-1:0] cur_pri;
    logic                 take;
    logic                 last;
    logic [IDX_WIDTH-1:0] win_idx;

    // The entry under the scan pointer beats the running best only when strictly higher
    always_comb begin
        cur_pri = pri[cnt];
        take    = req_q[cnt] && (cur_pri != '0) && (!best_valid || (cur_pri > best_pri));
        last    = (cnt == LAST_IDX);
        win_idx = take ? cnt : best_idx;
    end

    assign cfg_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // Single FSM owning the priority file, scan bookkeeping and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req_q      <= '0;
            cnt        <= '0;
            best_idx   <= '0;
            best_pri   <= '0;
            best_valid <= 1'b0;
            gnt_valid  <= 1'b0;
            gnt_index  <= '0;
            gnt_onehot <= '0;
            cfg_rdata  <= '0;
            cfg_rvalid <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                pri[i] <= PRI_WIDTH'(1);
            end
        end else begin
            cfg_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_valid) begin
                        if (cfg_wr_rd) begin
                            pri[cfg_index] <= cfg_wdata;
                        end else begin
                            cfg_rdata  <= pri[cfg_index];
                            cfg_rvalid <= 1'b1;
                        end
                    end else if (|req) begin
                        req_q      <= req;
                        cnt        <= '0;
                        best_valid <= 1'b0;
                        state      <= SCAN;
                    end
                end
                SCAN: begin
                    if (take) begin
                        best_valid <= 1'b1;
                        best_pri   <= cur_pri;
                        best_idx   <= cnt;
                    end
                    if (last) begin
                        if (take || best_valid) begin
                            gnt_valid  <= 1'b1;
                            gnt_index  <= win_idx;
                            gnt_onehot <= NUM_REQ'(1) << win_idx;
                            state      <= GRANT;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GRANT: begin
                    if (gnt_done) begin
                        gnt_valid  <= 1'b0;
                        gnt_onehot <= '0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_priority_scheduler.sv
// Testbench for prog_priority_scheduler: expected grants and read data are
// pushed to queues from a priority model as stimulus is driven, and popped
// when the DUT presents a grant or read response.
module tb_prog_priority_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req;
    logic        gnt_done;
    logic        gnt_valid;
    logic [3:0]  gnt_index;
    logic [15:0] gnt_onehot;
    logic        busy;
    logic        cfg_valid;
    logic        cfg_ready;
    logic        cfg_wr_rd;
    logic [3:0]  cfg_index;
    logic [4:0]  cfg_wdata;
    logic [4:0]  cfg_rdata;
    logic        cfg_rvalid;

    int          n_cmp = 0;
    int          n_err = 0;
    int          exp_gnt_q[$];
    logic [4:0]  exp_rd_q[$];
    logic [4:0]  model_pri[16];

    prog_priority_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .gnt_done   (gnt_done),
        .gnt_valid  (gnt_valid),
        .gnt_index  (gnt_index),
        .gnt_onehot (gnt_onehot),
        .busy       (busy),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_wr_rd  (cfg_wr_rd),
        .cfg_index  (cfg_index),
        .cfg_wdata  (cfg_wdata),
        .cfg_rdata  (cfg_rdata),
        .cfg_rvalid (cfg_rvalid)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Stop a hung run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Highest nonzero priority among requesters, lowest index on a tie; -1 if none
    function automatic int model_winner(logic [15:0] r);
        int maxp = 0;
        for (int i = 0; i < 16; i++)
            if (r[i] && int'(model_pri[i]) > maxp) maxp = int'(model_pri[i]);
        if (maxp == 0) return -1;
        for (int i = 0; i < 16; i++)
            if (r[i] && int'(model_pri[i]) == maxp) return i;
        return -1;
    endfunction

    task automatic wait_ready();
        int k = 0;
        while (!cfg_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!cfg_ready) begin
            n_cmp++;
            n_err++;
            $display("[TB] FAIL cfg_ready_timeout: got 0 expected 1");
        end
    endtask

    task automatic cfg_write(int idx, logic [4:0] d);
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_wr_rd = 1'b1;
        cfg_index = 4'(idx);
        cfg_wdata = d;
        wait_ready();
        @(negedge clk);
        cfg_valid = 1'b0;
        model_pri[idx] = d;
    endtask

    // Leaves the bench at the negedge where cfg_rvalid/cfg_rdata should be present
    task automatic cfg_read(int idx);
        exp_rd_q.push_back(model_pri[idx]);
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_wr_rd = 1'b0;
        cfg_index = 4'(idx);
        wait_ready();
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic start_req(logic [15:0] r);
        @(negedge clk);
        req = r;
    endtask

    task automatic wait_grant(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!gnt_valid && cycles < 60);
    endtask

    task automatic release_grant();
        req      = '0;
        gnt_done = 1'b1;
        @(negedge clk);
        gnt_done = 1'b0;
    endtask

    task automatic test_reset();
        int c;
        int e;
        logic [4:0] er;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (gnt_valid !== 1'b0) begin n_err++; $display("[TB] FAIL rst_gnt_valid: got %b expected 0", gnt_valid); end
        n_cmp++; if (gnt_index !== 4'd0) begin n_err++; $display("[TB] FAIL rst_gnt_index: got %0d expected 0", gnt_index); end
        n_cmp++; if (gnt_onehot !== 16'h0) begin n_err++; $display("[TB] FAIL rst_onehot: got %h expected 0000", gnt_onehot); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL rst_busy: got %b expected 0", busy); end
        n_cmp++; if (cfg_rdata !== 5'd0 || cfg_rvalid !== 1'b0) begin n_err++; $display("[TB] FAIL rst_cfg_out: got %0d/%b expected 0/0", cfg_rdata, cfg_rvalid); end
        n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("[TB] FAIL rst_cfg_ready: got %b expected 1", cfg_ready); end
        rst = 1'b0;

        start_req(16'h8001);
        exp_gnt_q.push_back(model_winner(16'h8001));
        wait_grant(c);
        e = exp_gnt_q.pop_front();
        n_cmp++; if (c != 17) begin n_err++; $display("[TB] FAIL tie_latency: got %0d expected 17", c); end
        n_cmp++; if (gnt_index !== 4'(e)) begin n_err++; $display("[TB] FAIL tie_index: got %0d expected %0d", gnt_index, e); end
        release_grant();

        cfg_read(7);
        er = exp_rd_q.pop_front();
        n_cmp++; if (cfg_rvalid !== 1'b1 || cfg_rdata !== er) begin n_err++; $display("[TB] FAIL read7: got %0d/%b expected %0d/1", cfg_rdata, cfg_rvalid, er); end
    endtask

    task automatic test_program();
        int c;
        int e;
        logic [15:0] eo;
        cfg_write(3, 5'd9);
        cfg_write(12, 5'd20);
        start_req(16'h1008);
        exp_gnt_q.push_back(model_winner(16'h1008));
        wait_grant(c);
        e  = exp_gnt_q.pop_front();
        eo = 16'(1) << e;
        n_cmp++; if (c != 17) begin n_err++; $display("[TB] FAIL prog_latency: got %0d expected 17", c); end
        n_cmp++; if (gnt_index !== 4'(e)) begin n_err++; $display("[TB] FAIL prog_index: got %0d expected %0d", gnt_index, e); end
        n_cmp++; if (gnt_onehot !== eo) begin n_err++; $display("[TB] FAIL prog_onehot: got %h expected %h", gnt_onehot, eo); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("[TB] FAIL prog_busy: got %b expected 1", busy); end
        release_grant();
        n_cmp++; if (gnt_valid !== 1'b0 || gnt_onehot !== 16'h0) begin n_err++; $display("[TB] FAIL prog_release: got %b/%h expected 0/0000", gnt_valid, gnt_onehot); end
    endtask

    task automatic test_masked();
        logic seen = 1'b0;
        logic busy16 = 1'b0;
        cfg_write(5, 5'd0);
        start_req(16'h0020);
        for (int i = 1; i <= 17; i++) begin
            @(negedge clk);
            if (i == 1) req = '0;
            seen |= gnt_valid;
            if (i == 16) busy16 = busy;
        end
        n_cmp++; if (busy16 !== 1'b1) begin n_err++; $display("[TB] FAIL masked_busy_scan: got %b expected 1", busy16); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL masked_busy_end: got %b expected 0", busy); end
        n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("[TB] FAIL masked_cfg_ready: got %b expected 1", cfg_ready); end
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("[TB] FAIL masked_no_grant: got %b expected 0", seen); end
    endtask

    task automatic test_stall();
        int c;
        int e;
        start_req(16'h0006);
        exp_gnt_q.push_back(model_winner(16'h0006));
        repeat (4) @(negedge clk);
        cfg_valid = 1'b1;
        cfg_wr_rd = 1'b1;
        cfg_index = 4'd2;
        cfg_wdata = 5'd31;
        n_cmp++; if (cfg_ready !== 1'b0) begin n_err++; $display("[TB] FAIL stall_ready_scan: got %b expected 0", cfg_ready); end
        wait_grant(c);
        e = exp_gnt_q.pop_front();
        n_cmp++; if (gnt_valid !== 1'b1 || gnt_index !== 4'(e)) begin n_err++; $display("[TB] FAIL stall_first_grant: got %b/%0d expected 1/%0d", gnt_valid, gnt_index, e); end
        n_cmp++; if (cfg_ready !== 1'b0) begin n_err++; $display("[TB] FAIL stall_ready_grant: got %b expected 0", cfg_ready); end
        model_pri[2] = 5'd31;
        exp_gnt_q.push_back(model_winner(16'h0006));
        gnt_done = 1'b1;
        @(negedge clk);
        gnt_done = 1'b0;
        n_cmp++; if (cfg_ready !== 1'b1 || gnt_valid !== 1'b0) begin n_err++; $display("[TB] FAIL stall_idle: got %b/%b expected 1/0", cfg_ready, gnt_valid); end
        @(negedge clk);
        cfg_valid = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL stall_cfg_first: got %b expected 0", busy); end
        wait_grant(c);
        e = exp_gnt_q.pop_front();
        n_cmp++; if (c != 17) begin n_err++; $display("[TB] FAIL stall_latency: got %0d expected 17", c); end
        n_cmp++; if (gnt_index !== 4'(e)) begin n_err++; $display("[TB] FAIL stall_second_grant: got %0d expected %0d", gnt_index, e); end
        release_grant();
    endtask

    task automatic test_hold();
        int c;
        int e;
        start_req(16'h0010);
        exp_gnt_q.push_back(model_winner(16'h0010));
        @(negedge clk);
        req = '0;
        wait_grant(c);
        e = exp_gnt_q.pop_front();
        n_cmp++; if (c != 16) begin n_err++; $display("[TB] FAIL hold_latency: got %0d expected 16", c); end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            n_cmp++;
            if (gnt_valid !== 1'b1 || gnt_index !== 4'(e)) begin
                n_err++;
                $display("[TB] FAIL hold_cycle%0d: got %b/%0d expected 1/%0d", i, gnt_valid, gnt_index, e);
            end
        end
        release_grant();
        n_cmp++; if (gnt_valid !== 1'b0) begin n_err++; $display("[TB] FAIL hold_release: got %b expected 0", gnt_valid); end
        gnt_done = 1'b1;
        @(negedge clk);
        gnt_done = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || gnt_valid !== 1'b0) begin n_err++; $display("[TB] FAIL idle_done_ignored: got %b/%b expected 0/0", busy, gnt_valid); end
    endtask

    task automatic test_back_to_back();
        int c;
        int e;
        start_req(16'h0300);
        exp_gnt_q.push_back(model_winner(16'h0300));
        exp_gnt_q.push_back(model_winner(16'h0300));
        wait_grant(c);
        e = exp_gnt_q.pop_front();
        n_cmp++; if (gnt_index !== 4'(e)) begin n_err++; $display("[TB] FAIL b2b_first: got %0d expected %0d", gnt_index, e); end
        gnt_done = 1'b1;
        @(negedge clk);
        gnt_done = 1'b0;
        n_cmp++; if (gnt_valid !== 1'b0) begin n_err++; $display("[TB] FAIL b2b_drop: got %b expected 0", gnt_valid); end
        wait_grant(c);
        e = exp_gnt_q.pop_front();
        n_cmp++; if (c != 17) begin n_err++; $display("[TB] FAIL b2b_latency: got %0d expected 17", c); end
        n_cmp++; if (gnt_index !== 4'(e)) begin n_err++; $display("[TB] FAIL b2b_second: got %0d expected %0d", gnt_index, e); end
        release_grant();
    endtask

    task automatic test_reset_mid();
        int c;
        int e;
        logic [4:0] er;
        start_req(16'h1FFF);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req = '0;
        n_cmp++; if (gnt_valid !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1) begin n_err++; $display("[TB] FAIL rst_scan: got %b/%b/%b expected 0/0/1", gnt_valid, busy, cfg_ready); end
        for (int i = 0; i < 16; i++) model_pri[i] = 5'd1;

        start_req(16'h0040);
        exp_gnt_q.push_back(model_winner(16'h0040));
        wait_grant(c);
        e = exp_gnt_q.pop_front();
        n_cmp++; if (gnt_valid !== 1'b1 || gnt_index !== 4'(e)) begin n_err++; $display("[TB] FAIL rst_pre_grant: got %b/%0d expected 1/%0d", gnt_valid, gnt_index, e); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req = '0;
        n_cmp++; if (gnt_valid !== 1'b0 || busy !== 1'b0 || gnt_onehot !== 16'h0 || gnt_index !== 4'd0) begin n_err++; $display("[TB] FAIL rst_grant: got %b/%b/%h/%0d expected 0/0/0000/0", gnt_valid, busy, gnt_onehot, gnt_index); end
        for (int i = 0; i < 16; i++) begin
            cfg_read(i);
            er = exp_rd_q.pop_front();
            n_cmp++;
            if (cfg_rvalid !== 1'b1 || cfg_rdata !== er) begin
                n_err++;
                $display("[TB] FAIL rst_pri%0d: got %0d/%b expected %0d/1", i, cfg_rdata, cfg_rvalid, er);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        req       = '0;
        gnt_done  = 1'b0;
        cfg_valid = 1'b0;
        cfg_wr_rd = 1'b0;
        cfg_index = '0;
        cfg_wdata = '0;
        for (int i = 0; i < 16; i++) model_pri[i] = 5'd1;
        $display("[TB] starting prog_priority_scheduler bench");
        test_reset();
        test_program();
        test_masked();
        test_stall();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
